// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: forward S-box, round constants, GF(2^8) helpers
// and the state byte convention used by the iterative encryptor.
//
// State byte convention: byte i (i = row + 4*col, column-major) of a
// 128-bit state s[127:0] sits at s[127-8*i -: 8], so byte 0 is the MSB byte.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Multiply by x in GF(2^8) modulo 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        logic [7:0] r;
        if (b[7]) begin
            r = {b[6:0], 1'b0} ^ 8'h1b;
        end else begin
            r = {b[6:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Round constant for rounds 1..10; anything else yields zero.
    function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = RCON[1];
            4'd2:    r = RCON[2];
            4'd3:    r = RCON[3];
            4'd4:    r = RCON[4];
            4'd5:    r = RCON[5];
            4'd6:    r = RCON[6];
            4'd7:    r = RCON[7];
            4'd8:    r = RCON[8];
            4'd9:    r = RCON[9];
            4'd10:   r = RCON[10];
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // MixColumns on one column; byte 0 (row 0) is the MSB byte of the word.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round:
// SubBytes -> ShiftRows -> MixColumns (skipped when last) -> AddRoundKey.
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] next_st
);

    logic [127:0] shifted;
    logic [127:0] mixed;

    // SubBytes and ShiftRows together: row r of column c takes column (c+r) mod 4.
    always_comb begin
        shifted = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127-8*(r+4*c) -: 8] = SBOX[st[127-8*(r+4*((c+r)%4)) -: 8]];
            end
        end
    end

    // MixColumns on every column unless this is the final round, then add the round key.
    always_comb begin
        mixed = 128'h0;
        if (last) begin
            mixed = shifted;
        end else begin
            for (int c = 0; c < 4; c++) begin
                mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
            end
        end
        next_st = mixed ^ round_key;
    end

endmodule

// File: rtl/aes128_cipher_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on
// the fly, valid/ready handshakes on input and output.
module aes128_cipher_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] plaintext,
    input  logic [0:127] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] ciphertext
);

    fsm_t         fsm;
    fsm_t         fsm_next;
    logic [127:0] st;
    logic [127:0] rk;
    logic [127:0] nk;
    logic [127:0] round_st;
    logic [3:0]   rnd;
    logic         last_round;
    logic         in_ready_next;
    logic         out_valid_next;

    // A stray round count beyond 10 is treated as final so the FSM always exits ROUND.
    assign last_round = (rnd >= LAST_ROUND);

    // Next round key from the current one, using the round constant of this round.
    always_comb begin
        logic [31:0] w0, w1, w2, w3, t;
        w0 = rk[127:96];
        w1 = rk[95:64];
        w2 = rk[63:32];
        w3 = rk[31:0];
        t  = sub_word(rot_word(w3)) ^ {rcon_of(rnd), 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        nk = {w0, w1, w2, w3};
    end

    aes_enc_round u_round (
        .st        (st),
        .round_key (nk),
        .last      (last_round),
        .next_st   (round_st)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    // Next-state logic: accept only in IDLE, ten rounds, then hold until drained.
    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE: begin
                if (in_valid) begin
                    fsm_next = ROUND;
                end else begin
                    fsm_next = IDLE;
                end
            end
            ROUND: begin
                if (last_round) begin
                    fsm_next = DONE;
                end else begin
                    fsm_next = ROUND;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_next = IDLE;
                end else begin
                    fsm_next = DONE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    // Handshake flags for the coming cycle, registered below so they track the state.
    always_comb begin
        in_ready_next  = (fsm_next == IDLE);
        out_valid_next = (fsm_next == DONE);
    end

    // Datapath registers: load whitened block on accept, advance one round per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            st  <= 128'h0;
            rk  <= 128'h0;
            rnd <= 4'd0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        st  <= plaintext ^ key;
                        rk  <= key;
                        rnd <= 4'd1;
                    end else begin
                        st  <= st;
                        rk  <= rk;
                        rnd <= rnd;
                    end
                end
                ROUND: begin
                    st  <= round_st;
                    rk  <= nk;
                    rnd <= rnd + 4'd1;
                end
                default: begin
                    st  <= st;
                    rk  <= rk;
                    rnd <= rnd;
                end
            endcase
        end
    end

    // Output registers: ciphertext captured as the final round completes, held through DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            ciphertext <= 128'h0;
        end else begin
            in_ready  <= in_ready_next;
            out_valid <= out_valid_next;
            if ((fsm == ROUND) && last_round) begin
                ciphertext <= round_st;
            end else begin
                ciphertext <= ciphertext;
            end
        end
    end

endmodule

// File: tb/tb_aes128_cipher_iter.sv
// Self-checking bench for aes128_cipher_iter: FIPS-197 vectors, latency,
// backpressure, back-to-back, mid-operation reset and random blocks against
// an independent software AES model (S-box derived from GF inverse + affine).
module tb_aes128_cipher_iter;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] plaintext;
    logic [0:127] key;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] ciphertext;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [3];
    logic [7:0] sb_tb [0:255];

    aes128_cipher_iter dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, v, xb, yb;
        for (int x = 0; x < 256; x++) begin
            xb = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                yb = y[7:0];
                if (gmul(xb, yb) == 8'h01) inv = yb;
            end
            v = inv ^ rotl1(inv) ^ rotl1(rotl1(inv)) ^ rotl1(rotl1(rotl1(inv)))
                ^ rotl1(rotl1(rotl1(rotl1(inv))));
            sb_tb[x] = v ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model_encrypt(input logic [127:0] p, input logic [127:0] k);
        logic [31:0]  w [0:43];
        logic [7:0]   s [0:15];
        logic [7:0]   t [0:15];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb_tb[tmp[31:24]], sb_tb[tmp[23:16]], sb_tb[tmp[15:8]], sb_tb[tmp[7:0]]}
                      ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int round = 1; round <= 10; round++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r+4*c] = sb_tb[s[r+4*((c+r)%4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (round < 10) begin
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*round + i/4][31-8*(i%4) -: 8];
        end
        res = 128'h0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // One full transaction with out_ready high; returns ciphertext and accept-to-valid cycles.
    task automatic run_block(input logic [127:0] p, input logic [127:0] k,
                             output logic [127:0] ct, output int lat);
        int guard;
        plaintext = p;
        key = k;
        out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        plaintext = ~p;
        key = ~k;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        ct = ciphertext;
        tick();
    endtask

    initial begin
        logic [127:0] ct, exp, p, k, hold_ct;
        logic [127:0] outs [2];
        int lat, guard, extra, n_acc, n_out;
        int acc_cyc [2];
        logic acc_now, out_now;

        vecs[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        build_sbox();

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        plaintext = 128'h0;
        key = 128'h0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("reset_in_ready", {127'h0, in_ready}, 128'h1);
        check("reset_out_valid", {127'h0, out_valid}, 128'h0);
        check("reset_ciphertext", ciphertext, 128'h0);

        // Known-answer vectors with latency check.
        for (int i = 0; i < 3; i++) begin
            run_block(vecs[i].pt, vecs[i].key, ct, lat);
            check($sformatf("kat%0d_ct", i), ct, vecs[i].ct);
            check($sformatf("kat%0d_latency", i), 128'(lat), 128'd10);
            check($sformatf("kat%0d_drained", i), {127'h0, out_valid}, 128'h0);
        end

        // Backpressure: hold out_ready low 20 cycles, stray in_valid pulse ignored.
        plaintext = vecs[1].pt;
        key = vecs[1].key;
        out_ready = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        plaintext = vecs[0].pt;
        key = vecs[0].key;
        guard = 0;
        while (!out_valid && guard < 50) begin
            tick();
            guard++;
        end
        check("bp_ct", ciphertext, vecs[1].ct);
        hold_ct = ciphertext;
        for (int i = 0; i < 20; i++) begin
            in_valid = (i == 5);
            tick();
            check("bp_stable_ct", ciphertext, hold_ct);
            check("bp_in_ready_low", {127'h0, in_ready}, 128'h0);
            check("bp_out_valid_high", {127'h0, out_valid}, 128'h1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_released_out_valid", {127'h0, out_valid}, 128'h0);
        check("bp_released_in_ready", {127'h0, in_ready}, 128'h1);
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) extra++;
        end
        check("bp_single_transfer", 128'(extra), 128'd0);

        // Back-to-back with in_valid held high: B then C.1.
        plaintext = vecs[0].pt;
        key = vecs[0].key;
        in_valid = 1'b1;
        out_ready = 1'b1;
        n_acc = 0;
        n_out = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        outs[0] = 128'h0;
        outs[1] = 128'h0;
        for (int cyc = 0; cyc < 60 && n_out < 2; cyc++) begin
            acc_now = in_valid && in_ready;
            out_now = out_valid && out_ready;
            if (out_now) begin
                outs[n_out] = ciphertext;
                n_out++;
            end
            tick();
            if (acc_now && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc == 1) begin
                    plaintext = vecs[1].pt;
                    key = vecs[1].key;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check("b2b_count", 128'(n_out), 128'd2);
        check("b2b_first_ct", outs[0], vecs[0].ct);
        check("b2b_second_ct", outs[1], vecs[1].ct);
        // 10 ROUND cycles, 1 DONE cycle, then the next accept happens in the IDLE cycle.
        check("b2b_accept_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'd12);
        tick();

        // Reset during round 5 of the App. B block.
        plaintext = vecs[0].pt;
        key = vecs[0].key;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        check("midreset_out_valid", {127'h0, out_valid}, 128'h0);
        check("midreset_ciphertext", ciphertext, 128'h0);
        check("midreset_in_ready", {127'h0, in_ready}, 128'h1);
        reset = 1'b0;
        run_block(vecs[1].pt, vecs[1].key, ct, lat);
        check("midreset_fresh_ct", ct, vecs[1].ct);
        check("midreset_fresh_latency", 128'(lat), 128'd10);

        // Random blocks against the software model.
        for (int n = 0; n < 1000; n++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            exp = model_encrypt(p, k);
            run_block(p, k, ct, lat);
            check("rand_ct", ct, exp);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
